// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/I-O stage: SRAM wait-state sequencing plus the keyboard/display device page.
// Define LC3_MEM_KBINT_EN to make KB_IE writable and drive int_req from KB_READY & KB_IE.
module lc3_mem_ctrl #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mem_rdata,
    output logic        r,
    output logic        sram_en,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic        kb_strobe,
    input  logic [7:0]  kb_char,
    input  logic        dsp_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_char,
    output logic        int_req
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(WAIT_STATES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [15:0] rdata_q, rdata_d;
    logic        kb_ready_q, kb_ready_d;
    logic [7:0]  kb_data_q, kb_data_d;
    logic        dsp_valid_q, dsp_valid_d;
    logic [7:0]  dsp_char_q, dsp_char_d;
    logic        kb_ie;
    logic        kb_clr;
    logic        dev_sel;
    logic [15:0] dev_rdata;

`ifdef LC3_MEM_KBINT_EN
    logic kb_ie_q, kb_ie_d;
    logic int_req_q;

    assign kb_ie   = kb_ie_q;
    assign int_req = int_req_q;

    // int_req tracks the next KBSR value so both become visible in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            kb_ie_q   <= 1'b0;
            int_req_q <= 1'b0;
        end else begin
            kb_ie_q   <= kb_ie_d;
            int_req_q <= kb_ready_d & kb_ie_d;
        end
    end
`else
    assign kb_ie   = 1'b0;
    assign int_req = 1'b0;
`endif

    assign dev_sel = (mar[15:9] == 7'h7F);

    always_comb begin
        dev_rdata = 16'h0000;
        case (mar)
            16'hFE00: dev_rdata = {kb_ready_q, kb_ie, 14'h0000};
            16'hFE02: dev_rdata = {8'h00, kb_data_q};
            16'hFE04: dev_rdata = {dsp_ready, 15'h0000};
            default:  dev_rdata = 16'h0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        dsp_char_d  = dsp_char_q;
        dsp_valid_d = 1'b0;
        kb_clr      = 1'b0;
        kb_data_d   = kb_strobe ? kb_char : kb_data_q;
`ifdef LC3_MEM_KBINT_EN
        kb_ie_d     = kb_ie_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (mio_en) begin
                    addr_d  = mar;
                    wdata_d = mdr_in;
                    we_d    = r_w;
                    if (dev_sel) begin
                        state_d = StDone;
                        if (r_w) begin
                            if (mar == 16'hFE00) begin
`ifdef LC3_MEM_KBINT_EN
                                kb_ie_d = mdr_in[14];
`endif
                            end else if (mar == 16'hFE06 && dsp_ready) begin
                                dsp_char_d  = mdr_in[7:0];
                                dsp_valid_d = 1'b1;
                            end
                        end else begin
                            rdata_d = dev_rdata;
                            kb_clr  = (mar == 16'hFE02);
                        end
                    end else begin
                        state_d = StAccess;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    if (!we_q) rdata_d = sram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A strobe coinciding with the KBDR read wins over the clear.
        kb_ready_d = kb_strobe | (kb_ready_q & ~kb_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            we_q        <= 1'b0;
            rdata_q     <= 16'h0000;
            kb_ready_q  <= 1'b0;
            kb_data_q   <= 8'h00;
            dsp_valid_q <= 1'b0;
            dsp_char_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            kb_ready_q  <= kb_ready_d;
            kb_data_q   <= kb_data_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_char_q  <= dsp_char_d;
        end
    end

    // Gating with reset keeps an in-flight write from reaching the SRAM on the reset edge.
    assign sram_en    = (state_q == StAccess) & ~reset;
    assign sram_we    = sram_en & we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign r          = (state_q == StDone);
    assign mem_rdata  = rdata_q;
    assign dsp_valid  = dsp_valid_q;
    assign dsp_char   = dsp_char_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: vector table plus hand sequences for reset and keyboard cases.
module tb_lc3_mem_ctrl;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mio_en, r_w;
    logic [15:0] mar, mdr_in;
    logic [15:0] mem_rdata;
    logic        r, sram_en, sram_we;
    logic [15:0] sram_addr, sram_wdata;
    logic [15:0] sram_rdata;
    logic        kb_strobe;
    logic [7:0]  kb_char;
    logic        dsp_ready, dsp_valid;
    logic [7:0]  dsp_char;
    logic        int_req;

    lc3_mem_ctrl #(.WAIT_STATES(WS)) dut (
        .clk        (clk),
        .reset      (reset),
        .mio_en     (mio_en),
        .r_w        (r_w),
        .mar        (mar),
        .mdr_in     (mdr_in),
        .mem_rdata  (mem_rdata),
        .r          (r),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .kb_strobe  (kb_strobe),
        .kb_char    (kb_char),
        .dsp_ready  (dsp_ready),
        .dsp_valid  (dsp_valid),
        .dsp_char   (dsp_char),
        .int_req    (int_req)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM with one cycle of read latency.
    logic [15:0] sram [0:65535];
    int en_cnt = 0;
    int dv_cnt = 0;
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) sram[sram_addr] <= sram_wdata;
            sram_rdata <= sram[sram_addr];
        end
        if (sram_en) en_cnt <= en_cnt + 1;
        if (dsp_valid) dv_cnt <= dv_cnt + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic strobe(input logic [7:0] ch);
        kb_strobe = 1'b1;
        kb_char   = ch;
        @(negedge clk);
        kb_strobe = 1'b0;
    endtask

    // Entered and left at a negedge; reports latency, data seen in the r cycle, and pulse counts.
    task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                             input logic kbs, input logic [7:0] kbc,
                             output int lat, output logic [15:0] rd, output int en, output int dv);
        int en0, dv0;
        en0 = en_cnt;
        dv0 = dv_cnt;
        mio_en    = 1'b1;
        r_w       = we;
        mar       = addr;
        mdr_in    = wd;
        kb_strobe = kbs;
        kb_char   = kbc;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mio_en    = 1'b0;
            kb_strobe = 1'b0;
            lat++;
            if (r) break;
        end
        rd = mem_rdata;
        @(negedge clk);
        en = en_cnt - en0;
        dv = dv_cnt - dv0;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        pre_kb;
        logic [7:0]  kbc;
        logic        dsp_rdy;
        int          lat;
        logic        chk_rd;
        logic [15:0] rdata;
        int          en;
        int          dv;
        logic [7:0]  dch;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int lat, en, dv;
        logic [15:0] rd;
        bit saw_r;

        tbl[0]  = '{1'b1, 16'h3000, 16'h1234, 1'b0, 8'h00, 1'b0, 3, 1'b0, 16'h0000, 2, 0, 8'h00};
        tbl[1]  = '{1'b0, 16'h3000, 16'h0000, 1'b0, 8'h00, 1'b0, 3, 1'b1, 16'h1234, 2, 0, 8'h00};
        tbl[2]  = '{1'b0, 16'hFE00, 16'h0000, 1'b1, 8'h41, 1'b0, 1, 1'b1, 16'h8000, 0, 0, 8'h00};
        tbl[3]  = '{1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00, 1'b0, 1, 1'b1, 16'h0041, 0, 0, 8'h00};
        tbl[4]  = '{1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00, 1'b0, 1, 1'b1, 16'h0000, 0, 0, 8'h00};
        tbl[5]  = '{1'b1, 16'hFE06, 16'h0158, 1'b0, 8'h00, 1'b1, 1, 1'b1, 16'h0000, 0, 1, 8'h58};
        tbl[6]  = '{1'b1, 16'hFE06, 16'h0123, 1'b0, 8'h00, 1'b0, 1, 1'b1, 16'h0000, 0, 0, 8'h58};
        tbl[7]  = '{1'b0, 16'hFE08, 16'h0000, 1'b0, 8'h00, 1'b0, 1, 1'b1, 16'h0000, 0, 0, 8'h58};
        tbl[8]  = '{1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00, 1'b1, 1, 1'b1, 16'h8000, 0, 0, 8'h58};
        tbl[9]  = '{1'b1, 16'h3001, 16'hBEEF, 1'b0, 8'h00, 1'b0, 3, 1'b1, 16'h8000, 2, 0, 8'h58};
        tbl[10] = '{1'b0, 16'h3001, 16'h0000, 1'b0, 8'h00, 1'b0, 3, 1'b1, 16'hBEEF, 2, 0, 8'h58};
        tbl[11] = '{1'b0, 16'hFE06, 16'h0000, 1'b0, 8'h00, 1'b1, 1, 1'b1, 16'h0000, 0, 0, 8'h58};

        reset = 1'b1; mio_en = 1'b0; r_w = 1'b0; mar = 16'h0; mdr_in = 16'h0;
        kb_strobe = 1'b0; kb_char = 8'h0; dsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_r", {31'd0, r}, 0);
        chk("rst_sram_en", {31'd0, sram_en}, 0);
        chk("rst_sram_we", {31'd0, sram_we}, 0);
        chk("rst_sram_addr", {16'd0, sram_addr}, 0);
        chk("rst_sram_wdata", {16'd0, sram_wdata}, 0);
        chk("rst_mem_rdata", {16'd0, mem_rdata}, 0);
        chk("rst_dsp_valid", {31'd0, dsp_valid}, 0);
        chk("rst_dsp_char", {24'd0, dsp_char}, 0);
        chk("rst_int_req", {31'd0, int_req}, 0);

        for (int i = 0; i < 12; i++) begin
            dsp_ready = tbl[i].dsp_rdy;
            if (tbl[i].pre_kb) strobe(tbl[i].kbc);
            do_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, 8'h00, lat, rd, en, dv);
            chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata", i), {16'd0, rd}, {16'd0, tbl[i].rdata});
            chk($sformatf("v%0d_sram_en_cycles", i), en, tbl[i].en);
            chk($sformatf("v%0d_dsp_valid_pulses", i), dv, tbl[i].dv);
            chk($sformatf("v%0d_dsp_char", i), {24'd0, dsp_char}, {24'd0, tbl[i].dch});
            chk($sformatf("v%0d_int_req", i), {31'd0, int_req}, 0);
        end

        // Strobe coinciding with a KBDR read: old char returned, ready stays set, new char kept.
        strobe(8'h42);
        do_access(1'b0, 16'hFE02, 16'h0, 1'b1, 8'h43, lat, rd, en, dv);
        chk("same_cyc_kbdr_old", {16'd0, rd}, 32'h0042);
        do_access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, lat, rd, en, dv);
        chk("same_cyc_kbsr_ready", {16'd0, rd}, 32'h8000);
        do_access(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h00, lat, rd, en, dv);
        chk("same_cyc_kbdr_new", {16'd0, rd}, 32'h0043);
        do_access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, lat, rd, en, dv);
        chk("same_cyc_kbsr_clr", {16'd0, rd}, 32'h0000);

        // Reset during the first ACCESS cycle of a write must leave the old SRAM word intact.
        do_access(1'b1, 16'h4000, 16'h5555, 1'b0, 8'h00, lat, rd, en, dv);
        mio_en = 1'b1; r_w = 1'b1; mar = 16'h4000; mdr_in = 16'h9999;
        @(negedge clk);
        mio_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_sram_en", {31'd0, sram_en}, 0);
        saw_r = r;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            saw_r = saw_r | r;
        end
        chk("rst_mid_no_r", {31'd0, saw_r}, 0);
        do_access(1'b0, 16'h4000, 16'h0, 1'b0, 8'h00, lat, rd, en, dv);
        chk("rst_mid_old_data", {16'd0, rd}, 32'h5555);

        // Keyboard interrupt enable.
        do_access(1'b1, 16'hFE00, 16'h4000, 1'b0, 8'h00, lat, rd, en, dv);
        chk("kbint_idle", {31'd0, int_req}, 0);
        strobe(8'h55);
`ifdef LC3_MEM_KBINT_EN
        chk("kbint_req_set", {31'd0, int_req}, 1);
        do_access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, lat, rd, en, dv);
        chk("kbint_kbsr", {16'd0, rd}, 32'hC000);
`else
        chk("kbint_req_off", {31'd0, int_req}, 0);
        do_access(1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, lat, rd, en, dv);
        chk("kbint_kbsr", {16'd0, rd}, 32'h8000);
`endif
        do_access(1'b0, 16'hFE02, 16'h0, 1'b0, 8'h00, lat, rd, en, dv);
        chk("kbint_kbdr", {16'd0, rd}, 32'h0055);
        chk("kbint_req_clr", {31'd0, int_req}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
